mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, giving the RAM depth in 32-bit words (power of two, at least 4).
REQ-002 The block SHALL have parameter AW, default $clog2(DEPTH), giving the RAM word-address width.
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, 1, meaning a CPU memory request is present.
REQ-006 The block SHALL have port req_ready, output, 1, meaning the block accepts a request this cycle.
REQ-007 The block SHALL have port req_we, input, 1, where 1 is a store and 0 is a load.
REQ-008 The block SHALL have port req_funct3, input, 3, the RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 The block SHALL have port req_addr, input, 32, the byte address.
REQ-010 The block SHALL have port req_wdata, input, 32, the store data (right-aligned).
REQ-011 The block SHALL have port resp_valid, output, 1, meaning a response is present.
REQ-012 The block SHALL have port resp_ready, input, 1, meaning the CPU consumes the response.
REQ-013 The block SHALL have port resp_rdata, output, 32, the load result after extension (0 for stores).
REQ-014 The block SHALL have port resp_err, output, 1, flagging a misaligned or illegal request.
REQ-015 The block SHALL have port ram_write_ena, output, 1, driving the word-RAM write enable.
REQ-016 The block SHALL have port ram_addr, output, AW, driving the word-RAM address.
REQ-017 The block SHALL have port ram_data_i, output, 32, driving the word-RAM write data.
REQ-018 The block SHALL have port ram_data_o, input, 32, receiving the word-RAM combinational read data.

Function
REQ-019 The FSM SHALL have states IDLE, RD, WR and RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 On req_valid&&req_ready, the block SHALL register we, funct3, addr and wdata, and move from IDLE to the next state.
REQ-021 The next state SHALL be RESP if the request is illegal, WR for SW, and RD otherwise (all loads, SB, SH).
REQ-022 A request SHALL be illegal, with resp_err=1, for: funct3 011/110/111; a store with funct3[2]=1; H/HU with addr[0]≠0; W with addr[1:0]≠0.
REQ-023 An illegal request SHALL NOT assert ram_write_ena.
REQ-024 ram_addr SHALL equal registered addr[AW+1:2]; upper address bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
REQ-025 In RD, the block SHALL capture ram_data_o; loads then go to RESP, while SB/SH go to WR.
REQ-026 In WR, ram_write_ena SHALL be 1 for exactly one cycle and ram_data_i SHALL hold the merged word; the state then moves to RESP.
REQ-027 The merged word SHALL be: for SW, wdata; for SB, the captured word with lane addr[1:0] replaced by wdata[7:0]; for SH, the captured word with halfword addr[1] replaced by wdata[15:0].
REQ-028 For loads, resp_rdata SHALL take the lane selected by addr[1:0]; B/H SHALL sign-extend and BU/HU SHALL zero-extend.
REQ-029 In RESP, resp_valid SHALL be 1 and resp_rdata/resp_err SHALL be stable until resp_ready; RESP goes to IDLE when resp_ready=1.
REQ-030 Latency from acceptance to first resp_valid SHALL be: illegal 1 cycle; LW/LH/LB/SW 2 cycles; SB/SH 3 cycles.
REQ-031 Throughput SHALL be one request per (latency+1) cycles; there SHALL be no request pipelining.
REQ-032 ram_write_ena SHALL equal (state==WR)&&!reset, so that no RAM write occurs in a cycle where reset is high (the RAM writes on the falling edge).

Reset
REQ-033 On reset, state SHALL go to IDLE and all registered fields SHALL clear to 0.
REQ-034 On reset, outputs SHALL be: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, ram_write_ena=0, ram_addr=0 and ram_data_i=0.
REQ-035 Reset asserted mid-operation (RD, WR or RESP) SHALL abandon the request with no write and no response.

Structure
REQ-036 Package mem_lsu_pkg SHALL hold the state encoding and the funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
REQ-037 Sub-module mem_lsu_lane (combinational) SHALL perform load extract/extend and store merge; the FSM and registers stay in mem_lsu.
REQ-038 The block SHALL be verified against generic_ram with READ_OLD=1 and DEPTH equal to this DEPTH.

Verification
REQ-039 The bench SHALL check: SW addr 0x10, data 0xDEADBEEF, then LW 0x10 -> rdata 0xDEADBEEF, err 0, SW response 2 cycles after acceptance.
REQ-040 The bench SHALL check: after the above, SB addr 0x11, data 0x55, then LW 0x10 -> 0xDEAD55EF; exactly one write pulse; response 3 cycles after acceptance.
REQ-041 The bench SHALL check: word 0x000080F0 at 0x20: LB 0x20 -> 0xFFFFFFF0; LBU 0x20 -> 0x000000F0; LH 0x20 -> 0xFFFF80F0; LHU 0x20 -> 0x000080F0.
REQ-042 The bench SHALL check: SH addr 0x21 -> err=1, response after 1 cycle, no write_ena pulse; LW addr 0x22 -> err=1; funct3 011 -> err=1.
REQ-043 The bench SHALL check: resp_ready held low 5 cycles -> resp_valid and data stable, req_ready=0 throughout; addr 4*DEPTH+8 aliases addr 8.
REQ-044 The bench SHALL check: reset pulsed while in WR of an SB -> no RAM change, resp_valid=0, req_ready=1 in the next cycle.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, RISC-V
// funct3 width codes and the request legality check.
package mem_lsu_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned widths exist only for loads; halfwords and words must be naturally aligned.
    function automatic logic is_illegal(input logic we, input logic [2:0] funct3,
                                        input logic [1:0] byte_off);
        logic bad;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = byte_off[0];
            F3_W:    bad = (byte_off != 2'b00);
            F3_BU:   bad = we;
            F3_HU:   bad = we | byte_off[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lsu_lane.sv
// Byte-lane datapath: extracts and extends load data from a RAM word and
// merges sub-word store data into the previously read word.
module mem_lsu_lane
    import mem_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (byte_off)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = byte_off[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            F3_W:    load_data = word;
            default: load_data = 32'd0;
        endcase
    end

    // Sub-word stores keep the untouched lanes of the word read in RD.
    always_comb begin
        merged = word;
        case (funct3)
            F3_B: merged[{byte_off, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (byte_off[1])
                    merged[31:16] = wdata[15:0];
                else
                    merged[15:0] = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Non-pipelined load/store unit between a CPU valid/ready port and a
// single-port word RAM with combinational read and falling-edge write.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic          ram_write_ena,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_data_i,
    input  logic [31:0]   ram_data_o
);

    logic [1:0]    state;
    logic          r_we;
    logic [2:0]    r_funct3;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_word;
    logic          r_err;
    logic          req_illegal;
    logic [31:0]   load_data;
    logic [31:0]   merged;

    // Bits above the RAM range are dropped so addresses wrap modulo the RAM size.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:AW+2];

    assign req_illegal = is_illegal(req_we, req_funct3, req_addr[1:0]);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            r_word   <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr[AW+1:0];
                        r_wdata  <= req_wdata;
                        r_word   <= 32'd0;
                        r_err    <= req_illegal;
                        if (req_illegal)
                            state <= S_RESP;
                        else if (req_we && req_funct3 == F3_W)
                            state <= S_WR;
                        else
                            state <= S_RD;
                    end
                end
                S_RD: begin
                    r_word <= ram_data_o;
                    state  <= r_we ? S_WR : S_RESP;
                end
                S_WR:    state <= S_RESP;
                S_RESP:  if (resp_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    mem_lsu_lane u_lane (
        .funct3    (r_funct3),
        .byte_off  (r_addr[1:0]),
        .word      (r_word),
        .wdata     (r_wdata),
        .load_data (load_data),
        .merged    (merged)
    );

    assign req_ready     = (state == S_IDLE);
    assign resp_valid    = (state == S_RESP);
    assign resp_err      = resp_valid && r_err;
    assign resp_rdata    = (resp_valid && !r_we && !r_err) ? load_data : 32'd0;
    // Gating with reset keeps the falling-edge RAM write from firing in a reset cycle.
    assign ram_write_ena = (state == S_WR) && !reset;
    assign ram_addr      = r_addr[AW+1:2];
    assign ram_data_i    = merged;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: byte-addressed reference model, a word RAM
// with combinational read and falling-edge write, directed and random requests.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);
    localparam int BYTES = 4 * DEPTH;

    logic          clock;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          ram_write_ena;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_data_i;
    logic [31:0]   ram_data_o;

    logic [31:0] ram_mem [DEPTH];
    logic [7:0]  model_bytes [BYTES];

    int          checks;
    int          errors;
    int          write_pulses;
    logic [31:0] exp_rdata;
    logic        exp_err;

    mem_lsu #(.DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .ram_write_ena (ram_write_ena),
        .ram_addr      (ram_addr),
        .ram_data_i    (ram_data_i),
        .ram_data_o    (ram_data_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign ram_data_o = ram_mem[ram_addr];

    always @(negedge clock) begin
        if (ram_write_ena)
            ram_mem[ram_addr] <= ram_data_i;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    // Every cycle a response is presented it must match the model's prediction.
    always @(negedge clock) begin
        if (ram_write_ena)
            write_pulses++;
        if (!reset && resp_valid) begin
            checkOutput("resp_rdata", resp_rdata, exp_rdata);
            checkOutput("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
        end
    end

    function automatic logic model_illegal(input logic we, input logic [2:0] f3,
                                           input logic [31:0] addr);
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
        if (we && f3[2]) return 1'b1;
        if ((f3 == F3_H || f3 == F3_HU) && addr[0]) return 1'b1;
        if (f3 == F3_W && addr[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_word(input int widx);
        return {model_bytes[4*widx+3], model_bytes[4*widx+2],
                model_bytes[4*widx+1], model_bytes[4*widx]};
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
        int i;
        logic [7:0] b0;
        logic [7:0] b1;
        i  = int'(addr % BYTES);
        b0 = model_bytes[i];
        b1 = model_bytes[(i + 1) % BYTES];
        case (f3)
            F3_B:    return {{24{b0[7]}}, b0};
            F3_BU:   return {24'd0, b0};
            F3_H:    return {{16{b1[7]}}, b1, b0};
            F3_HU:   return {16'd0, b1, b0};
            default: return model_word(i / 4);
        endcase
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata);
        int i;
        int n;
        i = int'(addr % BYTES);
        n = (f3 == F3_B) ? 1 : (f3 == F3_H) ? 2 : 4;
        for (int k = 0; k < n; k++)
            model_bytes[i + k] = wdata[8*k +: 8];
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int hold,
                                 output logic [31:0] got_rdata, output logic got_err,
                                 output int got_lat, output int got_writes);
        logic bad;
        int   exp_lat;
        int   w0;
        int   widx;
        bad       = model_illegal(we, f3, addr);
        exp_err   = bad;
        exp_rdata = (!we && !bad) ? model_load(f3, addr) : 32'd0;
        exp_lat   = bad ? 1 : (we && f3 != F3_W) ? 3 : 2;
        got_rdata = 32'd0;
        got_err   = 1'b0;
        got_writes = 0;
        w0 = write_pulses;

        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        @(negedge clock);
        checkOutput("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clock);
        #1 req_valid = 1'b0;

        got_lat = 1;
        @(negedge clock);
        while (!resp_valid && got_lat < 8) begin
            got_lat++;
            @(negedge clock);
        end
        if (!resp_valid) begin
            checkOutput("resp_timeout", 32'd0, 32'd1);
            return;
        end
        checkOutput("latency", 32'(got_lat), 32'(exp_lat));
        got_rdata  = resp_rdata;
        got_err    = resp_err;
        got_writes = write_pulses - w0;
        checkOutput("write_pulses", 32'(got_writes), (we && !bad) ? 32'd1 : 32'd0);

        for (int i = 0; i < hold; i++) begin
            checkOutput("hold_valid", {31'd0, resp_valid}, 32'd1);
            checkOutput("hold_req_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clock);
        end
        resp_ready = 1'b1;
        @(posedge clock);
        #1 resp_ready = 1'b0;

        if (we && !bad)
            model_store(f3, addr, wdata);
        widx = int'(addr % BYTES) / 4;
        checkOutput("ram_word", ram_mem[widx], model_word(widx));
    endtask

    logic [31:0] r;
    logic        e;
    int          lat;
    int          wr;
    int          w_before;

    initial begin
        checks = 0;
        errors = 0;
        write_pulses = 0;
        exp_rdata = 32'd0;
        exp_err = 1'b0;
        for (int i = 0; i < DEPTH; i++) ram_mem[i] = 32'd0;
        for (int i = 0; i < BYTES; i++) model_bytes[i] = 8'd0;
        reset = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_funct3 = 3'd0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        resp_ready = 1'b0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
        checkOutput("rst_resp_err", {31'd0, resp_err}, 32'd0);
        checkOutput("rst_write_ena", {31'd0, ram_write_ena}, 32'd0);
        checkOutput("rst_ram_addr", {{(32-AW){1'b0}}, ram_addr}, 32'd0);
        checkOutput("rst_ram_data_i", ram_data_i, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        applyStimulus(1'b1, F3_W, 32'h10, 32'hDEADBEEF, 0, r, e, lat, wr);
        checkOutput("sw10_lat", 32'(lat), 32'd2);
        checkOutput("sw10_writes", 32'(wr), 32'd1);
        applyStimulus(1'b0, F3_W, 32'h10, 32'd0, 0, r, e, lat, wr);
        checkOutput("lw10_rdata", r, 32'hDEADBEEF);
        checkOutput("lw10_err", {31'd0, e}, 32'd0);

        applyStimulus(1'b1, F3_B, 32'h11, 32'h55, 0, r, e, lat, wr);
        checkOutput("sb11_lat", 32'(lat), 32'd3);
        checkOutput("sb11_writes", 32'(wr), 32'd1);
        applyStimulus(1'b0, F3_W, 32'h10, 32'd0, 0, r, e, lat, wr);
        checkOutput("lw10_merged", r, 32'hDEAD55EF);

        applyStimulus(1'b1, F3_W, 32'h20, 32'h000080F0, 0, r, e, lat, wr);
        applyStimulus(1'b0, F3_B, 32'h20, 32'd0, 0, r, e, lat, wr);
        checkOutput("lb20", r, 32'hFFFFFFF0);
        applyStimulus(1'b0, F3_BU, 32'h20, 32'd0, 0, r, e, lat, wr);
        checkOutput("lbu20", r, 32'h000000F0);
        applyStimulus(1'b0, F3_H, 32'h20, 32'd0, 0, r, e, lat, wr);
        checkOutput("lh20", r, 32'hFFFF80F0);
        applyStimulus(1'b0, F3_HU, 32'h20, 32'd0, 0, r, e, lat, wr);
        checkOutput("lhu20", r, 32'h000080F0);

        applyStimulus(1'b1, F3_H, 32'h21, 32'h1234, 0, r, e, lat, wr);
        checkOutput("sh21_err", {31'd0, e}, 32'd1);
        checkOutput("sh21_lat", 32'(lat), 32'd1);
        checkOutput("sh21_writes", 32'(wr), 32'd0);
        applyStimulus(1'b0, F3_W, 32'h22, 32'd0, 0, r, e, lat, wr);
        checkOutput("lw22_err", {31'd0, e}, 32'd1);
        applyStimulus(1'b0, 3'b011, 32'h0, 32'd0, 0, r, e, lat, wr);
        checkOutput("f3_011_err", {31'd0, e}, 32'd1);

        applyStimulus(1'b0, F3_W, 32'h10, 32'd0, 5, r, e, lat, wr);
        checkOutput("hold_rdata", r, 32'hDEAD55EF);

        applyStimulus(1'b1, F3_W, 32'(BYTES + 8), 32'h12345678, 0, r, e, lat, wr);
        applyStimulus(1'b0, F3_W, 32'h8, 32'd0, 0, r, e, lat, wr);
        checkOutput("alias_rdata", r, 32'h12345678);

        // Abandon an SB by pulsing reset while it sits in its write cycle.
        applyStimulus(1'b1, F3_W, 32'h40, 32'hA5A5A5A5, 0, r, e, lat, wr);
        w_before = write_pulses;
        req_we = 1'b1;
        req_funct3 = F3_B;
        req_addr = 32'h41;
        req_wdata = 32'h3C;
        req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        checkOutput("rst_wr_no_ena", {31'd0, ram_write_ena}, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checkOutput("rst_wr_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("rst_wr_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_wr_ram", ram_mem[16], 32'hA5A5A5A5);
        checkOutput("rst_wr_pulses", 32'(write_pulses - w_before), 32'd0);
        @(posedge clock);
        #1;

        for (int n = 0; n < 120; n++) begin
            logic [31:0] a;
            logic [2:0]  f;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            f = 3'($urandom_range(0, 7));
            applyStimulus(1'($urandom_range(0, 1)), f, a, $urandom,
                          int'($urandom_range(0, 2)), r, e, lat, wr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
